// File: rtl/cam_match_unit.sv
// ---------------------------------------------------------------------------
// cam_match_unit
//
// Key-storage and match side of the CAM datapath. Holds DATA_LINES keys with
// valid bits and executes LOOKUP / INSERT / DELETE / CLEAR operations. The
// result is a one-hot line select (res_sel) for the CAM output multiplexer,
// plus hit / full flags and the number of valid entries.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   op_valid/op_ready   op request handshake (op_ready high only in IDLE)
//   op_code             00 LOOKUP, 01 INSERT, 10 DELETE, 11 CLEAR
//   op_key              key for the op (ignored for CLEAR)
//   res_valid/res_ready result handshake
//   res_hit             key matched a valid entry
//   res_sel             one-hot matched/written entry, else 0
//   res_full            INSERT rejected because no entry was free
//   entry_count         number of valid entries
//   fsm_state           debug view of the control FSM state
//   hit_index           binary encode of res_sel (only with CAM_INDEX_OUT_EN)
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. The producer holds its payload stable
// while valid is high and ready is low. op_ready does not depend on op_valid;
// res_valid does not depend on res_ready.
//
// Configuration macro: CAM_INDEX_OUT_EN adds the hit_index output.
// ---------------------------------------------------------------------------
module cam_match_unit #(
  parameter int KEY_WIDTH  = 32,
  parameter int DATA_LINES = 4,
  localparam int CW = $clog2(DATA_LINES + 1),
  localparam int IW = (DATA_LINES > 1) ? $clog2(DATA_LINES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [1:0]            op_code,
  input  logic [KEY_WIDTH-1:0]  op_key,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_hit,
  output logic [DATA_LINES-1:0] res_sel,
  output logic                  res_full,
  output logic [CW-1:0]         entry_count,
`ifdef CAM_INDEX_OUT_EN
  output logic [IW-1:0]         hit_index,
`endif
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_CLEAR  = 2'b11
  } op_t;

  state_t                  state_q, state_d;
  op_t                     op_code_q, op_code_d;
  logic [KEY_WIDTH-1:0]    op_key_q, op_key_d;
  logic [KEY_WIDTH-1:0]    keys_q [DATA_LINES];
  logic [KEY_WIDTH-1:0]    keys_d [DATA_LINES];
  logic [DATA_LINES-1:0]   valid_q, valid_d;
  logic                    res_valid_q, res_valid_d;
  logic                    res_hit_q, res_hit_d;
  logic [DATA_LINES-1:0]   res_sel_q, res_sel_d;
  logic                    res_full_q, res_full_d;
  logic [CW-1:0]           count_q, count_d;

  logic [DATA_LINES-1:0]   match;
  logic [DATA_LINES-1:0]   free_sel;
  logic                    found_free;

  always_comb begin
    state_d     = state_q;
    op_code_d   = op_code_q;
    op_key_d    = op_key_q;
    keys_d      = keys_q;
    valid_d     = valid_q;
    res_valid_d = res_valid_q;
    res_hit_d   = res_hit_q;
    res_sel_d   = res_sel_q;
    res_full_d  = res_full_q;
    match       = '0;
    free_sel    = '0;
    found_free  = 1'b0;

    // Only valid lines can match; because INSERT never writes a key that
    // already hits, at most one bit of match is ever set.
    for (int i = 0; i < DATA_LINES; i++) begin
      match[i] = valid_q[i] && (keys_q[i] == op_key_q);
    end

    // Lowest-index free line as a one-hot vector.
    for (int i = 0; i < DATA_LINES; i++) begin
      if (!valid_q[i] && !found_free) begin
        free_sel[i] = 1'b1;
        found_free  = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          op_code_d = op_t'(op_code);
          op_key_d  = op_key;
          state_d   = S_COMPARE;
        end
      end

      // Table update and result are committed on the same edge.
      S_COMPARE: begin
        state_d     = S_RESPOND;
        res_valid_d = 1'b1;
        res_hit_d   = |match;
        res_sel_d   = '0;
        res_full_d  = 1'b0;
        unique case (op_code_q)
          OP_LOOKUP: res_sel_d = match;
          OP_INSERT: begin
            if (|match) begin
              res_sel_d = match;
            end else if (found_free) begin
              res_sel_d = free_sel;
              valid_d   = valid_q | free_sel;
              for (int i = 0; i < DATA_LINES; i++) begin
                if (free_sel[i]) keys_d[i] = op_key_q;
              end
            end else begin
              res_full_d = 1'b1;
            end
          end
          OP_DELETE: begin
            res_sel_d = match;
            valid_d   = valid_q & ~match;
          end
          OP_CLEAR: begin
            res_hit_d = 1'b0;
            valid_d   = '0;
          end
        endcase
      end

      S_RESPOND: begin
        if (res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
          res_hit_d   = 1'b0;
          res_sel_d   = '0;
          res_full_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    count_d = '0;
    for (int i = 0; i < DATA_LINES; i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_code_q   <= OP_LOOKUP;
      op_key_q    <= '0;
      valid_q     <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_sel_q   <= '0;
      res_full_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_code_q   <= op_code_d;
      op_key_q    <= op_key_d;
      valid_q     <= valid_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      res_sel_q   <= res_sel_d;
      res_full_q  <= res_full_d;
      count_q     <= count_d;
    end
  end

  // Key storage has no reset: a line's contents are meaningless until its
  // valid bit is set, and writes only happen in COMPARE.
  always_ff @(posedge clk) begin
    keys_q <= keys_d;
  end

`ifdef CAM_INDEX_OUT_EN
  logic [IW-1:0] hit_index_q, hit_index_d;

  always_comb begin
    hit_index_d = '0;
    for (int i = 0; i < DATA_LINES; i++) begin
      if (res_sel_d[i]) hit_index_d = IW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hit_index_q <= '0;
    else       hit_index_q <= hit_index_d;
  end

  assign hit_index = hit_index_q;
`endif

  assign op_ready    = (state_q == S_IDLE);
  assign res_valid   = res_valid_q;
  assign res_hit     = res_hit_q;
  assign res_sel     = res_sel_q;
  assign res_full    = res_full_q;
  assign entry_count = count_q;
  assign fsm_state   = state_q;

endmodule
